// File: rtl/switch_debounce_pkg.sv
// Shared constants for the board-input debouncer: channel map into the GPIO input bus
// and a width helper for the internal counters.
package switch_debounce_pkg;

    localparam int unsigned DebounceWidth = 16;

    localparam int unsigned DB_NAV_BASE = 0;
    localparam int unsigned DB_NAV_BITS = 5;
    localparam int unsigned DB_USR_BASE = 5;
    localparam int unsigned DB_USR_BITS = 8;
    localparam int unsigned DB_SEL_BASE = 13;
    localparam int unsigned DB_SEL_BITS = 3;

    // Bits needed to hold the range 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/switch_debounce_chan.sv
// One debounce channel: counts consecutive sample ticks on which the synchronised input
// disagrees with the settled level, and flips the level once the count completes.
module switch_debounce_chan
    import switch_debounce_pkg::*;
#(
    parameter int unsigned StableSamples = 8,
    parameter logic        ResetVal      = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    input  logic tick_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o,
    output logic flip_o
);

    localparam int unsigned CntW = cnt_width(StableSamples);

    logic [CntW-1:0] cnt_q;

    // Combinational look-ahead of the flip, so the parent can register its event flag
    // in the same cycle the pulses appear.
    assign flip_o = (sync_i != sw_o) && tick_i && (cnt_q == CntW'(StableSamples - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            sw_o   <= ResetVal;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (sync_i == sw_o) begin
                cnt_q <= '0;
            end else if (tick_i) begin
                if (flip_o) begin
                    cnt_q  <= '0;
                    sw_o   <= sync_i;
                    rise_o <= sync_i;
                    fall_o <= ~sync_i;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Board-input debouncer: optional per-pin inversion, 2-FF synchroniser, shared sample-tick
// divider, per-channel stability filters and a sticky change flag.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int unsigned      Width         = DebounceWidth,
    parameter int unsigned      SysClkFreq    = 40_000_000,
    parameter int unsigned      SampleHz      = 1_000,
    parameter int unsigned      StableSamples = 8,
    parameter logic [Width-1:0] InvertMask    = '1,
    parameter logic [Width-1:0] ResetVal      = '0
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic             enable_i,
    input  logic [Width-1:0] raw_i,
    output logic [Width-1:0] sw_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic             evt_o,
    input  logic             evt_clr_i
);

    localparam int unsigned TickDiv = SysClkFreq / SampleHz;
    localparam int unsigned DivW    = cnt_width(TickDiv - 1);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;
    logic [DivW-1:0]  div_q;
    logic             tick;
    logic [Width-1:0] flip;

    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= raw_i ^ InvertMask;
            sync_q <= meta_q;
        end
    end

    assign tick = enable_i && (div_q == DivW'(TickDiv - 1));

    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            div_q <= '0;
        end else if (enable_i) begin
            div_q <= tick ? '0 : div_q + 1'b1;
        end
    end

    for (genvar i = 0; i < Width; i++) begin : g_chan
        switch_debounce_chan #(
            .StableSamples(StableSamples),
            .ResetVal     (ResetVal[i])
        ) u_chan (
            .clk_i (clk_sys_i),
            .rst_ni(rst_sys_ni),
            .sync_i(sync_q[i]),
            .tick_i(tick),
            .sw_o  (sw_o[i]),
            .rise_o(rise_o[i]),
            .fall_o(fall_o[i]),
            .flip_o(flip[i])
        );
    end

    // Set takes priority over clear so a flip coinciding with a clear is not lost.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            evt_o <= 1'b0;
        end else begin
            evt_o <= (evt_o & ~evt_clr_i) | (|flip);
        end
    end

    a_tick_div: assert property (@(posedge clk_sys_i) TickDiv >= 1);
    a_stable:   assert property (@(posedge clk_sys_i) StableSamples >= 1);
    a_excl:     assert property (@(posedge clk_sys_i) (rise_o & fall_o) == '0);

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed scenarios plus randomized pin activity, checked
// against a cycle-level reference model of the debounce rules.
module tb_switch_debounce;

    localparam int unsigned W   = 4;
    localparam int unsigned TD  = 10;
    localparam int unsigned SS  = 3;
    localparam logic [3:0]  INV = 4'b1111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         evt_clr;
    logic [W-1:0] raw;
    logic [W-1:0] sw_o;
    logic [W-1:0] rise_o;
    logic [W-1:0] fall_o;
    logic         evt_o;

    always #5 clk = ~clk;

    switch_debounce #(
        .Width        (W),
        .SysClkFreq   (100),
        .SampleHz     (10),
        .StableSamples(SS),
        .InvertMask   (INV),
        .ResetVal     (4'b0000)
    ) dut (
        .clk_sys_i (clk),
        .rst_sys_ni(rst_n),
        .enable_i  (enable),
        .raw_i     (raw),
        .sw_o      (sw_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .evt_o     (evt_o),
        .evt_clr_i (evt_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: pin history, sample phase, per-channel run lengths.
    logic [W-1:0] m_pin_d = '0;
    logic [W-1:0] m_sync  = '0;
    logic [W-1:0] m_sw    = '0;
    logic [W-1:0] m_rise  = '0;
    logic [W-1:0] m_fall  = '0;
    logic         m_evt   = 1'b0;
    logic         m_tick  = 1'b0;
    int           m_phase = 0;
    int           m_run[W];

    task automatic step();
        logic [W-1:0] flip;
        @(posedge clk);
        flip   = '0;
        m_tick = 1'b0;
        if (!rst_n) begin
            m_pin_d = '0;
            m_sync  = '0;
            m_sw    = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_evt   = 1'b0;
            m_phase = 0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            m_tick = enable && (m_phase == TD - 1);
            for (int i = 0; i < W; i++) begin
                if (m_sync[i] == m_sw[i]) begin
                    m_run[i] = 0;
                end else if (m_tick) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == SS) begin
                        flip[i]  = 1'b1;
                        m_run[i] = 0;
                    end
                end
            end
            m_rise  = flip & m_sync;
            m_fall  = flip & ~m_sync;
            m_sw    = m_sw ^ flip;
            m_evt   = (m_evt && !evt_clr) || (flip != '0);
            if (enable) m_phase = (m_phase + 1) % TD;
            m_sync  = m_pin_d;
            m_pin_d = raw ^ INV;
        end
        cyc++;
        #1;
    endtask

    function automatic logic flip_next0();
        return enable && (m_phase == TD - 1) && (m_sync[0] != m_sw[0]) && (m_run[0] == SS - 1);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; raw = 4'hF; enable = 1'b1; evt_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if ({sw_o, rise_o, fall_o, evt_o} !== 13'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got sw=%b rise=%b fall=%b evt=%b, want all 0", cyc, sw_o, rise_o, fall_o, evt_o);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            n_checks++;
            if ({sw_o, rise_o, fall_o, evt_o} !== 13'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got sw=%b rise=%b fall=%b evt=%b, want all 0", cyc, sw_o, rise_o, fall_o, evt_o);
            end
        end
    endtask

    task automatic test_clean_press();
        int t;
        int first = -1;
        int pulses = 0;
        raw[0] = 1'b0;
        t = cyc;
        for (int k = 0; k < 40; k++) begin
            step();
            n_checks++;
            if ({sw_o, rise_o, fall_o, evt_o} !== {m_sw, m_rise, m_fall, m_evt}) begin
                n_fail++;
                $display("FAIL press_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", cyc, sw_o, rise_o, fall_o, evt_o, m_sw, m_rise, m_fall, m_evt);
            end
            if (rise_o[0]) begin
                pulses++;
                if (first < 0) first = cyc;
            end
        end
        n_checks++;
        if (first < t + 23 || first > t + 32) begin
            n_fail++;
            $display("FAIL press_latency got rise at %0d, want within [%0d,%0d]", first, t + 23, t + 32);
        end
        n_checks++;
        if (pulses != 1 || sw_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL press_pulse got pulses=%0d sw0=%b, want 1 pulse and sw0=1", pulses, sw_o[0]);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (evt_o !== 1'b1) begin
                n_fail++;
                $display("FAIL press_evt_sticky cyc=%0d got evt=%b want 1", cyc, evt_o);
            end
        end
        evt_clr = 1'b1;
        step();
        evt_clr = 1'b0;
        n_checks++;
        if (evt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL evt_clear got evt=%b want 0", evt_o);
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 110; k++) begin
            if (k < 70 && k % 7 == 0) raw[1] = ~raw[1];
            if (k == 70) raw[1] = 1'b1;
            step();
            n_checks++;
            if (sw_o[1] !== 1'b0 || rise_o[1] !== 1'b0 || fall_o[1] !== 1'b0 || evt_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce cyc=%0d got sw1=%b rise1=%b fall1=%b evt=%b want 0/0/0/0", cyc, sw_o[1], rise_o[1], fall_o[1], evt_o);
            end
            n_checks++;
            if ({sw_o, rise_o, fall_o, evt_o} !== {m_sw, m_rise, m_fall, m_evt}) begin
                n_fail++;
                $display("FAIL bounce_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", cyc, sw_o, rise_o, fall_o, evt_o, m_sw, m_rise, m_fall, m_evt);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic seen = 1'b0;
        raw[0] = 1'b1;
        raw[2] = 1'b0;
        for (int k = 0; k < 45 && !seen; k++) begin
            evt_clr = flip_next0();
            step();
            evt_clr = 1'b0;
            n_checks++;
            if ({sw_o, rise_o, fall_o, evt_o} !== {m_sw, m_rise, m_fall, m_evt}) begin
                n_fail++;
                $display("FAIL simul_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", cyc, sw_o, rise_o, fall_o, evt_o, m_sw, m_rise, m_fall, m_evt);
            end
            if (rise_o != '0 || fall_o != '0) begin
                seen = 1'b1;
                n_checks++;
                if (rise_o !== 4'b0100 || fall_o !== 4'b0001 || evt_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL simul_pulses got rise=%b fall=%b evt=%b want 0100/0001/1", rise_o, fall_o, evt_o);
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL simul_timeout got no pulse within 45 cycles, want one");
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (evt_o !== 1'b1 || rise_o !== 4'b0 || fall_o !== 4'b0) begin
                n_fail++;
                $display("FAIL simul_after got evt=%b rise=%b fall=%b want 1/0000/0000", evt_o, rise_o, fall_o);
            end
        end
    endtask

    task automatic test_enable_hold();
        int ticks = 0;
        logic done = 1'b0;
        raw[3] = 1'b0;
        for (int k = 0; k < 40 && m_run[3] != 1; k++) step();
        n_checks++;
        if (m_run[3] != 1) begin
            n_fail++;
            $display("FAIL enable_first_tick got run=%0d want 1", m_run[3]);
        end
        enable = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            n_checks++;
            if (sw_o[3] !== 1'b0 || rise_o[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_hold cyc=%0d got sw3=%b rise3=%b want 0/0", cyc, sw_o[3], rise_o[3]);
            end
        end
        enable = 1'b1;
        for (int k = 0; k < 30 && !done; k++) begin
            step();
            if (m_tick) ticks++;
            n_checks++;
            if (ticks < 2 && sw_o[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_early cyc=%0d got sw3=%b after %0d ticks want 0", cyc, sw_o[3], ticks);
            end else if (ticks == 2 && (sw_o[3] !== 1'b1 || rise_o[3] !== 1'b1)) begin
                n_fail++;
                $display("FAIL enable_resume cyc=%0d got sw3=%b rise3=%b want 1/1", cyc, sw_o[3], rise_o[3]);
            end
            if (ticks == 2) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL enable_timeout got %0d ticks want 2", ticks);
        end
    endtask

    task automatic test_reset_mid();
        int ticks = 0;
        logic done = 1'b0;
        raw[0] = 1'b0;
        for (int k = 0; k < 40 && m_run[0] != 2; k++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++;
        if (sw_o !== 4'b0 || rise_o !== 4'b0 || fall_o !== 4'b0 || evt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state got sw=%b rise=%b fall=%b evt=%b want 0", sw_o, rise_o, fall_o, evt_o);
        end
        for (int k = 0; k < 45 && !done; k++) begin
            step();
            if (m_tick) ticks++;
            n_checks++;
            if (ticks < 3 && sw_o[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_early cyc=%0d got sw0=%b after %0d ticks want 0", cyc, sw_o[0], ticks);
            end else if (ticks == 3 && (sw_o[0] !== 1'b1 || rise_o[0] !== 1'b1)) begin
                n_fail++;
                $display("FAIL midreset_flip cyc=%0d got sw0=%b rise0=%b want 1/1", cyc, sw_o[0], rise_o[0]);
            end
            if (ticks == 3) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL midreset_timeout got %0d ticks want 3", ticks);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int k = 0; k < 700; k++) begin
            if (hold == 0) begin
                raw  = raw ^ W'(1 << $urandom_range(0, W - 1));
                hold = $urandom_range(1, 45);
            end else begin
                hold--;
            end
            enable  = ($urandom_range(0, 9) != 0);
            evt_clr = ($urandom_range(0, 15) == 0);
            step();
            n_checks++;
            if ({sw_o, rise_o, fall_o, evt_o} !== {m_sw, m_rise, m_fall, m_evt}) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", cyc, sw_o, rise_o, fall_o, evt_o, m_sw, m_rise, m_fall, m_evt);
            end
        end
        enable  = 1'b1;
        evt_clr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < W; i++) m_run[i] = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_enable_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
